// File: rtl/riscv_pkg.sv
// Shared RISC-V core constants used by the front-end blocks.
// No logic; compile before any module that imports it.
// XLEN sets the width of PCs and branch targets.
package riscv_pkg;
    localparam int XLEN = 32;
endpackage

// File: rtl/btb_update_ctrl.sv
// Purpose: queues resolved branch updates from EX into the BTB and sweeps every entry invalid after reset/flush.
// Latency: an update enqueued in cycle N is written to the BTB in cycle N+1 at the earliest; a sweep lasts ENTRIES cycles.
// Backpressure: ex_upd_ready drops when the queue is full (no same-cycle bypass); the queue only drains outside the sweep.
// Optional macro BTB_UPD_COALESCE_EN: an offer matching the youngest queued PC rewrites that entry's target instead of allocating.
module btb_update_ctrl
    import riscv_pkg::*;
#(
    parameter int ENTRIES = 64,
    parameter int QDEPTH  = 4
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             ex_upd_valid,
    output logic                             ex_upd_ready,
    input  logic [XLEN-1:0]                  ex_upd_pc,
    input  logic [XLEN-1:0]                  ex_upd_target,
    input  logic                             ex_upd_is_br,
    input  logic                             flush_req,
    output logic                             btb_update_en,
    output logic [XLEN-1:0]                  btb_pc_update,
    output logic [XLEN-1:0]                  btb_target_update,
    output logic                             btb_is_branch_or_jmp,
    output logic                             btb_inval_en,
    output logic [$clog2(ENTRIES)-1:0]       btb_inval_idx,
    output logic                             btb_lookup_en,
    output logic                             busy
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam int PTR_W = $clog2(QDEPTH);

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [PTR_W:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]    rd_ptr_q, rd_ptr_d;
    logic [XLEN-1:0]   pc_q  [QDEPTH];
    logic [XLEN-1:0]   pc_d  [QDEPTH];
    logic [XLEN-1:0]   tgt_q [QDEPTH];
    logic [XLEN-1:0]   tgt_d [QDEPTH];

    logic [PTR_W-1:0]  wr_idx;
    logic [PTR_W-1:0]  rd_idx;
    logic [PTR_W-1:0]  young_idx;
    logic [PTR_W:0]    young_ptr;
    logic              empty;
    logic              full;
    logic              deq;
    logic              take;
    logic              alloc;
    logic              merge;
    logic              coalesce_hit;

    assign wr_idx    = wr_ptr_q[PTR_W-1:0];
    assign rd_idx    = rd_ptr_q[PTR_W-1:0];
    assign young_ptr = wr_ptr_q - 1'b1;
    assign young_idx = young_ptr[PTR_W-1:0];
    assign empty     = (wr_ptr_q == rd_ptr_q);
    assign full      = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) && (wr_idx == rd_idx);

    // Head drains one entry per cycle in RUN; a flush or reset in the same cycle suppresses the write.
    assign deq = (state_q == ST_RUN) && !empty && !flush_req && !reset;

`ifdef BTB_UPD_COALESCE_EN
    logic [PTR_W:0] count;
    assign count = wr_ptr_q - rd_ptr_q;
    // The youngest entry can only be rewritten if it is not leaving the queue this same cycle.
    assign coalesce_hit = !empty && (pc_q[young_idx] == ex_upd_pc)
                          && !(deq && (count == (PTR_W+1)'(1)));
    assign ex_upd_ready = !full || coalesce_hit;
`else
    assign coalesce_hit = 1'b0;
    assign ex_upd_ready = !full;
`endif

    // Non-branch offers complete the handshake but are dropped; flush wins over any enqueue.
    assign take  = ex_upd_valid && ex_upd_ready && ex_upd_is_br && !flush_req;
    assign alloc = take && !coalesce_hit;
    assign merge = take && coalesce_hit;

    // Next-state: queue writes, pointer motion, sweep counter and flush handling.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        pc_d     = pc_q;
        tgt_d    = tgt_q;

        if (alloc) begin
            pc_d[wr_idx]  = ex_upd_pc;
            tgt_d[wr_idx] = ex_upd_target;
            wr_ptr_d      = wr_ptr_q + 1'b1;
        end
        if (merge) begin
            tgt_d[young_idx] = ex_upd_target;
        end
        if (deq) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end

        case (state_q)
            ST_CLEAR: begin
                if (idx_q == IDX_W'(ENTRIES - 1)) begin
                    state_d = ST_RUN;
                    idx_d   = '0;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            default: begin
                idx_d = '0;
            end
        endcase

        if (flush_req) begin
            state_d  = ST_CLEAR;
            idx_d    = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end
    end

    // State registers; queue payload is not reset since the pointers define validity.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_CLEAR;
            idx_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
        pc_q  <= pc_d;
        tgt_q <= tgt_d;
    end

    assign btb_update_en        = deq;
    assign btb_is_branch_or_jmp = deq;
    assign btb_pc_update        = pc_q[rd_idx];
    assign btb_target_update    = tgt_q[rd_idx];
    assign btb_inval_en         = (state_q == ST_CLEAR) && !reset;
    assign btb_inval_idx        = idx_q;
    assign btb_lookup_en        = (state_q == ST_RUN);
    assign busy                 = (state_q == ST_CLEAR) || !empty;

endmodule

// File: tb/tb_btb_update_ctrl.sv
// Directed bench for btb_update_ctrl with default parameters (64 entries, 4-deep queue).
// Inputs change 1ns after the rising edge; outputs are compared a further 1ns later.
// Build with BTB_UPD_COALESCE_EN defined to exercise the coalescing expectations.
module tb_btb_update_ctrl;
    import riscv_pkg::*;

    localparam int ENTRIES = 64;
    localparam int QDEPTH  = 4;
    localparam int IDX_W   = 6;

    logic             clk = 1'b0;
    logic             reset;
    logic             ex_upd_valid;
    logic             ex_upd_ready;
    logic [XLEN-1:0]  ex_upd_pc;
    logic [XLEN-1:0]  ex_upd_target;
    logic             ex_upd_is_br;
    logic             flush_req;
    logic             btb_update_en;
    logic [XLEN-1:0]  btb_pc_update;
    logic [XLEN-1:0]  btb_target_update;
    logic             btb_is_branch_or_jmp;
    logic             btb_inval_en;
    logic [IDX_W-1:0] btb_inval_idx;
    logic             btb_lookup_en;
    logic             busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    btb_update_ctrl #(.ENTRIES(ENTRIES), .QDEPTH(QDEPTH)) dut (
        .clk                  (clk),
        .reset                (reset),
        .ex_upd_valid         (ex_upd_valid),
        .ex_upd_ready         (ex_upd_ready),
        .ex_upd_pc            (ex_upd_pc),
        .ex_upd_target        (ex_upd_target),
        .ex_upd_is_br         (ex_upd_is_br),
        .flush_req            (flush_req),
        .btb_update_en        (btb_update_en),
        .btb_pc_update        (btb_pc_update),
        .btb_target_update    (btb_target_update),
        .btb_is_branch_or_jmp (btb_is_branch_or_jmp),
        .btb_inval_en         (btb_inval_en),
        .btb_inval_idx        (btb_inval_idx),
        .btb_lookup_en        (btb_lookup_en),
        .busy                 (busy)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        ex_upd_valid  = 1'b0;
        ex_upd_is_br  = 1'b0;
        ex_upd_pc     = '0;
        ex_upd_target = '0;
        flush_req     = 1'b0;
    endtask

    task automatic offer(input logic is_br, input logic [XLEN-1:0] pc, input logic [XLEN-1:0] tgt);
        ex_upd_valid  = 1'b1;
        ex_upd_is_br  = is_br;
        ex_upd_pc     = pc;
        ex_upd_target = tgt;
    endtask

    // Walk the sweep from index 'from' through ENTRIES-1; returns positioned in the first RUN cycle.
    task automatic clear_run(input int from);
        for (int i = from; i < ENTRIES; i++) begin
            idle();
            #1;
            chk("clr_idx",    64'(btb_inval_idx), 64'(i));
            chk("clr_inval",  64'(btb_inval_en),  64'd1);
            chk("clr_upd",    64'(btb_update_en), 64'd0);
            chk("clr_lookup", 64'(btb_lookup_en), 64'd0);
            tick();
        end
    endtask

    initial begin
        idle();
        reset = 1'b1;
        tick();
        #1;
        chk("rst_cycle_upd",   64'(btb_update_en), 64'd0);
        chk("rst_cycle_inval", 64'(btb_inval_en),  64'd0);
        tick();

        // First cycle after reset.
        reset = 1'b0;
        #1;
        chk("post_rst_inval", 64'(btb_inval_en),  64'd1);
        chk("post_rst_idx",   64'(btb_inval_idx), 64'd0);
        chk("post_rst_upd",   64'(btb_update_en), 64'd0);
        chk("post_rst_look",  64'(btb_lookup_en), 64'd0);
        chk("post_rst_ready", 64'(ex_upd_ready),  64'd1);
        chk("post_rst_busy",  64'(busy),          64'd1);
        clear_run(0);

        // 65th cycle: RUN.
        #1;
        chk("run_lookup", 64'(btb_lookup_en), 64'd1);
        chk("run_inval",  64'(btb_inval_en),  64'd0);
        chk("run_busy",   64'(busy),          64'd0);

        // Single update, one-cycle latency.
        offer(1'b1, 32'h100, 32'h200);
        #1;
        chk("lat_ready",   64'(ex_upd_ready),  64'd1);
        chk("lat_upd_n",   64'(btb_update_en), 64'd0);
        tick();
        idle();
        #1;
        chk("lat_upd_n1",  64'(btb_update_en),        64'd1);
        chk("lat_pc",      64'(btb_pc_update),        64'h100);
        chk("lat_tgt",     64'(btb_target_update),    64'h200);
        chk("lat_isbj",    64'(btb_is_branch_or_jmp), 64'd1);
        chk("lat_busy_n1", 64'(busy),                 64'd1);
        tick();
        #1;
        chk("lat_upd_n2",  64'(btb_update_en), 64'd0);
        chk("lat_busy_n2", 64'(busy),          64'd0);

        // Non-branch offer is acknowledged and dropped.
        offer(1'b0, 32'h40, 32'h44);
        #1;
        chk("nobr_ready", 64'(ex_upd_ready), 64'd1);
        tick();
        idle();
        #1;
        chk("nobr_upd1", 64'(btb_update_en), 64'd0);
        chk("nobr_busy", 64'(busy),          64'd0);
        tick();
        #1;
        chk("nobr_upd2", 64'(btb_update_en), 64'd0);

        // Flush in RUN, then fill the queue during the sweep.
        flush_req = 1'b1;
        tick();
        idle();
        for (int i = 0; i < 4; i++) begin
            offer(1'b1, 32'h1000 + 32'(4 * i), 32'h2000 + 32'(i));
            #1;
            chk("fill_ready", 64'(ex_upd_ready),  64'd1);
            chk("fill_idx",   64'(btb_inval_idx), 64'(i));
            tick();
        end
        offer(1'b1, 32'h5000, 32'h5555);
        #1;
        chk("full_ready", 64'(ex_upd_ready),  64'd0);
        chk("full_busy",  64'(busy),          64'd1);
        chk("full_upd",   64'(btb_update_en), 64'd0);
        tick();
        clear_run(5);

        // Drain in order; ready stays low while full even though the head leaves.
        #1;
        chk("nobypass_ready", 64'(ex_upd_ready),     64'd0);
        chk("drain0_upd",     64'(btb_update_en),    64'd1);
        chk("drain0_pc",      64'(btb_pc_update),    64'h1000);
        chk("drain0_tgt",     64'(btb_target_update), 64'h2000);
        tick();
        offer(1'b1, 32'h3000, 32'h4000);
        #1;
        chk("simul_ready", 64'(ex_upd_ready),  64'd1);
        chk("drain1_upd",  64'(btb_update_en), 64'd1);
        chk("drain1_pc",   64'(btb_pc_update), 64'h1004);
        tick();
        idle();
        #1;
        chk("drain2_upd", 64'(btb_update_en), 64'd1);
        chk("drain2_pc",  64'(btb_pc_update), 64'h1008);
        tick();
        #1;
        chk("drain3_upd", 64'(btb_update_en),     64'd1);
        chk("drain3_pc",  64'(btb_pc_update),     64'h100c);
        chk("drain3_tgt", 64'(btb_target_update), 64'h2003);
        tick();
        #1;
        chk("drain4_upd", 64'(btb_update_en),     64'd1);
        chk("drain4_pc",  64'(btb_pc_update),     64'h3000);
        chk("drain4_tgt", 64'(btb_target_update), 64'h4000);
        tick();
        #1;
        chk("drained_upd",  64'(btb_update_en), 64'd0);
        chk("drained_busy", 64'(busy),          64'd0);

        // Flush mid-sweep at index 30 with a same-cycle offer.
        flush_req = 1'b1;
        tick();
        idle();
        offer(1'b1, 32'h6000, 32'h6100);
        tick();
        offer(1'b1, 32'h6004, 32'h6104);
        tick();
        idle();
        for (int i = 2; i < 30; i++) tick();
        offer(1'b1, 32'h7000, 32'h7100);
        flush_req = 1'b1;
        #1;
        chk("midflush_idx",   64'(btb_inval_idx), 64'd30);
        chk("midflush_ready", 64'(ex_upd_ready),  64'd1);
        tick();
        idle();
        #1;
        chk("midflush_restart", 64'(btb_inval_idx), 64'd0);
        chk("midflush_inval",   64'(btb_inval_en),  64'd1);
        for (int i = 0; i < 3; i++) begin
            offer(1'b1, 32'h8000 + 32'(4 * i), 32'h8800 + 32'(i));
            #1;
            chk("refill_ready", 64'(ex_upd_ready), 64'd1);
            tick();
        end
        idle();
        #1;
        chk("midflush_emptied", 64'(ex_upd_ready), 64'd1);
        clear_run(3);

        // Flush in RUN with three queued: nothing may be written.
        flush_req = 1'b1;
        #1;
        chk("runflush_upd",  64'(btb_update_en), 64'd0);
        chk("runflush_look", 64'(btb_lookup_en), 64'd1);
        tick();
        idle();
        #1;
        chk("runflush_idx",   64'(btb_inval_idx), 64'd0);
        chk("runflush_inval", 64'(btb_inval_en),  64'd1);
        chk("runflush_look2", 64'(btb_lookup_en), 64'd0);
        clear_run(0);
        #1;
        chk("runflush_after_upd",  64'(btb_update_en), 64'd0);
        chk("runflush_after_busy", 64'(busy),          64'd0);

        // Same PC offered twice back to back while the queue is held.
        flush_req = 1'b1;
        tick();
        idle();
        offer(1'b1, 32'h80, 32'h10);
        #1;
        chk("coal_ready0", 64'(ex_upd_ready), 64'd1);
        tick();
        offer(1'b1, 32'h80, 32'h20);
        #1;
        chk("coal_ready1", 64'(ex_upd_ready), 64'd1);
        tick();
        clear_run(2);
        #1;
        chk("coal_upd0", 64'(btb_update_en), 64'd1);
        chk("coal_pc0",  64'(btb_pc_update), 64'h80);
`ifdef BTB_UPD_COALESCE_EN
        chk("coal_tgt0", 64'(btb_target_update), 64'h20);
        tick();
        #1;
        chk("coal_upd1", 64'(btb_update_en), 64'd0);
`else
        chk("coal_tgt0", 64'(btb_target_update), 64'h10);
        tick();
        #1;
        chk("coal_upd1", 64'(btb_update_en),     64'd1);
        chk("coal_pc1",  64'(btb_pc_update),     64'h80);
        chk("coal_tgt1", 64'(btb_target_update), 64'h20);
`endif
        tick();
        #1;
        chk("coal_done_upd",  64'(btb_update_en), 64'd0);
        chk("coal_done_busy", 64'(busy),          64'd0);

        // Reset during a drain aborts it without writing.
        flush_req = 1'b1;
        tick();
        idle();
        offer(1'b1, 32'ha0, 32'hb0);
        tick();
        offer(1'b1, 32'ha4, 32'hb4);
        tick();
        clear_run(2);
        reset = 1'b1;
        #1;
        chk("rstdrain_upd",   64'(btb_update_en), 64'd0);
        chk("rstdrain_inval", 64'(btb_inval_en),  64'd0);
        tick();
        reset = 1'b0;
        #1;
        chk("rstdrain_idx",   64'(btb_inval_idx), 64'd0);
        chk("rstdrain_inv1",  64'(btb_inval_en),  64'd1);
        chk("rstdrain_ready", 64'(ex_upd_ready),  64'd1);
        clear_run(0);
        #1;
        chk("rstdrain_after_upd",  64'(btb_update_en), 64'd0);
        chk("rstdrain_after_busy", 64'(busy),          64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
